innings_scorer: RTL
===================

Name: innings_scorer

Overview:
- Consumes the single-cycle `play` pulse from the button debouncer; each accepted pulse is one delivered ball.
- Draws a ball outcome from an internal LFSR, or from a forced code, and updates runs, wickets, balls and overs.
- Ends the innings on overs or wickets exhausted.
- Outputs feed the seven-segment and LED display logic.

Parameters:
- MAX_OVERS, 20, overs per innings (1..31)
- BALLS_PER_OVER, 6, legal balls per over (1..7)
- MAX_WICKETS, 10, wickets ending the innings (1..15)
- LFSR_SEED, 16'hACE1, LFSR value after reset and at innings start; must be nonzero

Ports:
- clk_fpga  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts an innings
- play  in  1  single-cycle debounced ball pulse
- force_en  in  1  when 1, outcome comes from force_code instead of the LFSR
- force_code  in  3  forced outcome code
- runs  out  10  innings total runs
- wickets  out  4  wickets fallen
- overs  out  5  completed overs
- balls  out  3  legal balls in the current over
- last_code  out  3  outcome code of the most recent scored ball
- ball_valid  out  1  one-cycle strobe, aligned with counter update
- innings_done  out  1  level, high in DONE

Behaviour:
- Reset (sync, active-high, Already decided): one clock clk_fpga; reset is synchronous and active-high.
  - All outputs go to 0, FSM goes to IDLE, LFSR loads LFSR_SEED.
  - Reset mid-innings discards all state.
- FSM states IDLE, PLAY, DONE.
  - IDLE: play ignored. start -> clear counters, LFSR=LFSR_SEED, go to PLAY.
  - PLAY: play is accepted and scored. start -> clear counters and reseed, stay in PLAY.
  - DONE: play ignored. innings_done=1. start -> clear, reseed, go to PLAY.
- start and play in the same cycle: start wins, play is dropped.
- Accepted play at cycle N:
  - Code sampled = force_en ? force_code : lfsr[2:0].
  - At N+1: counters and last_code are updated and ball_valid=1 for exactly one cycle.
  - The LFSR advances one step (x^16+x^14+x^13+x^11, Fibonacci) only on accepted play.
- Outcome codes:
  - 0 = dot
  - 1 = +1
  - 2 = +2
  - 3 = +3
  - 4 = +4
  - 5 = +6
  - 6 = wicket (0 runs, wickets+1)
  - 7 = see EXTRAS_EN
- Legal ball: balls+1. If balls reaches BALLS_PER_OVER, then balls=0 and overs+1 in the same update.
- Innings end: after an update, if overs==MAX_OVERS or wickets==MAX_WICKETS, the FSM enters DONE at the same N+1 edge. innings_done=1 from N+1.
- Runs saturate at 1023; this cannot occur with the default parameters.
- A play arriving in the cycle ball_valid is high is scored normally. No back-pressure is needed because play pulses are far apart.

Optional Feature:
- Macro EXTRAS_EN.
- Defined: code 7 = wide. Runs+1, balls and overs unchanged, the ball does not count toward the over. ball_valid still strobes.
- Undefined: code 7 = +1 run, legal ball (treated as code 1, but last_code reports 7).

Decomposition:
- Package innings_pkg:
  - outcome code constants (OC_DOT..OC_EXTRA)
  - FSM state enum (IDLE, PLAY, DONE)
  - runs-per-code lookup function
  - LFSR tap constant
- Sub-module lfsr16_step: 16-bit LFSR with seed load, enable and value output; instantiated once.
- Scoring, counter and FSM logic stay in innings_scorer.

Test Plan:
- Reset, then play x3 in IDLE -> runs=0, balls=0, ball_valid never high. Then start, then play with force code 4 -> at N+1, runs=4, balls=1, ball_valid pulse of one cycle.
- Start, then 6 plays forcing code 1 -> after the 6th, balls=0, overs=1, runs=6.
- Start, then 10 plays forcing code 6 -> wickets=10, innings_done=1 at the 10th update. An 11th play leaves all counters unchanged.
- MAX_OVERS=1: start, then 6 plays forcing code 5 -> runs=36, overs=1, DONE. Then start -> all counters 0, state PLAY.
- Force code 7 x2:
  - with EXTRAS_EN: runs=2, balls=0;
  - without EXTRAS_EN: runs=2, balls=2, last_code=7.
- Start, then play with force_en=0 from seed -> last_code = LFSR_SEED[2:0] = 1, runs=1. A reset mid-innings followed by start reproduces an identical outcome sequence.

Source files
------------

// File: rtl/innings_pkg.sv
// Shared outcome codes, FSM states, LFSR taps and run lookup for the innings scorer.
// Build option EXTRAS_EN is consumed by innings_scorer, not here.
package innings_pkg;

    localparam logic [2:0] OC_DOT    = 3'd0;
    localparam logic [2:0] OC_ONE    = 3'd1;
    localparam logic [2:0] OC_TWO    = 3'd2;
    localparam logic [2:0] OC_THREE  = 3'd3;
    localparam logic [2:0] OC_FOUR   = 3'd4;
    localparam logic [2:0] OC_SIX    = 3'd5;
    localparam logic [2:0] OC_WICKET = 3'd6;
    localparam logic [2:0] OC_EXTRA  = 3'd7;

    // Feedback taps of x^16+x^14+x^13+x^11 for a right-shifting Fibonacci register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [9:0] RUNS_MAX = 10'd1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [2:0] runs_for_code(input logic [2:0] code);
        case (code)
            OC_ONE:   return 3'd1;
            OC_TWO:   return 3'd2;
            OC_THREE: return 3'd3;
            OC_FOUR:  return 3'd4;
            OC_SIX:   return 3'd6;
            OC_EXTRA: return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// 16-bit Fibonacci LFSR: load forces SEED, en advances one step, otherwise holds.
module lfsr16_step
    import innings_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    output logic [15:0] value
);

    logic fb;

    assign fb = ^(value & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (load) begin
            value <= SEED;
        end else if (en) begin
            value <= {fb, value[15:1]};
        end
    end

endmodule

// File: rtl/innings_scorer.sv
// Innings scorer: IDLE/PLAY/DONE FSM scoring one ball per accepted play pulse.
// Define EXTRAS_EN to make code 7 a wide (run, no legal ball); otherwise it scores as a legal single.
module innings_scorer
    import innings_pkg::*;
#(
    parameter int          MAX_OVERS      = 20,
    parameter int          BALLS_PER_OVER = 6,
    parameter int          MAX_WICKETS    = 10,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic       start,
    input  logic       play,
    input  logic       force_en,
    input  logic [2:0] force_code,
    output logic [9:0] runs,
    output logic [3:0] wickets,
    output logic [4:0] overs,
    output logic [2:0] balls,
    output logic [2:0] last_code,
    output logic       ball_valid,
    output logic       innings_done
);

    localparam logic [3:0] BPO = 4'(BALLS_PER_OVER);
    localparam logic [4:0] MO  = 5'(MAX_OVERS);
    localparam logic [3:0] MW  = 4'(MAX_WICKETS);

    state_t      state;
    logic [15:0] lfsr_q;
    logic        lfsr_hi_unused;
    logic        vld_p0;
    logic [2:0]  code_p0;
    logic        legal_p0;
    logic [9:0]  runs_nx;
    logic [3:0]  wkts_nx;
    logic [4:0]  overs_nx;
    logic [2:0]  balls_nx;

    function automatic logic [9:0] sat_add_runs(input logic [9:0] a, input logic [2:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {8'd0, b};
        return s[10] ? RUNS_MAX : s[9:0];
    endfunction

    lfsr16_step #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk_fpga),
        .load  (reset | start),
        .en    (vld_p0),
        .value (lfsr_q)
    );

    // Only the low three bits pick the outcome
    assign lfsr_hi_unused = ^lfsr_q[15:3];

    // start takes priority, so a coincident play is dropped
    assign vld_p0  = (state == PLAY) && play && !start;
    assign code_p0 = force_en ? force_code : lfsr_q[2:0];

    always_comb begin
        legal_p0 = 1'b1;
`ifdef EXTRAS_EN
        if (code_p0 == OC_EXTRA) legal_p0 = 1'b0;
`else
        legal_p0 = 1'b1;
`endif
        runs_nx  = sat_add_runs(runs, runs_for_code(code_p0));
        wkts_nx  = wickets + {3'd0, (code_p0 == OC_WICKET)};
        balls_nx = balls;
        overs_nx = overs;
        if (legal_p0) begin
            if (({1'b0, balls} + 4'd1) == BPO) begin
                balls_nx = 3'd0;
                overs_nx = overs + 5'd1;
            end else begin
                balls_nx = balls + 3'd1;
            end
        end
    end

    // ---- p0 -> registered outputs ----
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state        <= IDLE;
            runs         <= '0;
            wickets      <= '0;
            overs        <= '0;
            balls        <= '0;
            last_code    <= '0;
            ball_valid   <= 1'b0;
            innings_done <= 1'b0;
        end else if (start) begin
            state        <= PLAY;
            runs         <= '0;
            wickets      <= '0;
            overs        <= '0;
            balls        <= '0;
            last_code    <= '0;
            ball_valid   <= 1'b0;
            innings_done <= 1'b0;
        end else begin
            ball_valid <= 1'b0;
            if (vld_p0) begin
                runs       <= runs_nx;
                wickets    <= wkts_nx;
                overs      <= overs_nx;
                balls      <= balls_nx;
                last_code  <= code_p0;
                ball_valid <= 1'b1;
                if ((overs_nx == MO) || (wkts_nx == MW)) begin
                    state        <= DONE;
                    innings_done <= 1'b1;
                end
            end
        end
    end

endmodule
